// File: rtl/apb2axi_bridge.sv
// rtl/apb2axi_bridge.sv - APB3 slave to AXI4 single-beat master bridge
module apb2axi_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 6,
    parameter int          USER_WIDTH = 6,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // APB slave
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    // AXI write address
    output logic [ID_WIDTH-1:0]     aw_id_o,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic                    aw_lock_o,
    output logic [3:0]              aw_cache_o,
    output logic [2:0]              aw_prot_o,
    output logic [3:0]              aw_region_o,
    output logic [3:0]              aw_qos_o,
    output logic [USER_WIDTH-1:0]   aw_user_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    output logic [USER_WIDTH-1:0]   w_user_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    // AXI write response
    input  logic [ID_WIDTH-1:0]     b_id_i,
    input  logic [1:0]              b_resp_i,
    input  logic [USER_WIDTH-1:0]   b_user_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    // AXI read address
    output logic [ID_WIDTH-1:0]     ar_id_o,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic                    ar_lock_o,
    output logic [3:0]              ar_cache_o,
    output logic [2:0]              ar_prot_o,
    output logic [3:0]              ar_region_o,
    output logic [3:0]              ar_qos_o,
    output logic [USER_WIDTH-1:0]   ar_user_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    // AXI read data
    input  logic [ID_WIDTH-1:0]     r_id_i,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_last_i,
    input  logic [USER_WIDTH-1:0]   r_user_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] AXI_SIZE   = 3'($clog2(STRB_WIDTH));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  cap_q, cap_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    // Response id/user, r_last and the low resp bit carry nothing the APB side can use.
    logic unused_inputs;
    assign unused_inputs = ^{b_id_i, b_user_i, b_resp_i[0], r_id_i, r_last_i, r_user_i, r_resp_i[0]};

    // Fixed single-beat transaction attributes.
    assign aw_id_o     = ID_WIDTH'(AXI_ID);
    assign aw_addr_o   = addr_q;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = AXI_SIZE;
    assign aw_burst_o  = 2'b01;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_region_o = 4'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_user_o   = '0;

    assign w_data_o    = wdata_q;
    assign w_strb_o    = '1;
    assign w_last_o    = 1'b1;
    assign w_user_o    = '0;

    assign ar_id_o     = ID_WIDTH'(AXI_ID);
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = AXI_SIZE;
    assign ar_burst_o  = 2'b01;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_region_o = 4'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_user_o   = '0;

    assign prdata_o    = rdata_q;

    // State and transfer context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cap_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state and handshake outputs; setup is captured in IDLE and launched on the AXI side the following cycle.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        ar_valid_o = 1'b0;
        b_ready_o  = 1'b0;
        r_ready_o  = 1'b0;
        pready_o   = 1'b0;
        pslverr_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (cap_q) begin
                    cap_d   = 1'b0;
                    state_d = write_q ? ST_WR_REQ : ST_RD_REQ;
                end else if (psel_i && !penable_i) begin
                    cap_d   = 1'b1;
                    write_d = pwrite_i;
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                end
            end
            ST_WR_REQ: begin
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
                aw_done_d  = aw_done_q || aw_ready_i;
                w_done_d   = w_done_q || w_ready_i;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    err_d   = b_resp_i[1];
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                r_ready_o = 1'b1;
                if (r_valid_i) begin
                    rdata_d = r_data_i;
                    err_d   = r_resp_i[1];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pready_o  = 1'b1;
                pslverr_o = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb2axi_bridge.sv
// tb/tb_apb2axi_bridge.sv - directed plus randomized bench for apb2axi_bridge
module tb_apb2axi_bridge;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        psel_i, penable_i, pwrite_i;
    logic [31:0] paddr_i, pwdata_i, prdata_o;
    logic        pready_o, pslverr_o;
    logic [5:0]  aw_id_o, aw_user_o, w_user_o, ar_id_o, ar_user_o;
    logic [31:0] aw_addr_o, ar_addr_o, w_data_o;
    logic [7:0]  aw_len_o, ar_len_o;
    logic [2:0]  aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
    logic [1:0]  aw_burst_o, ar_burst_o;
    logic        aw_lock_o, ar_lock_o;
    logic [3:0]  aw_cache_o, ar_cache_o, aw_region_o, ar_region_o, aw_qos_o, ar_qos_o;
    logic        aw_valid_o, aw_ready_i, ar_valid_o, ar_ready_i;
    logic [3:0]  w_strb_o;
    logic        w_last_o, w_valid_o, w_ready_i;
    logic [5:0]  b_id_i, b_user_i, r_id_i, r_user_i;
    logic [1:0]  b_resp_i, r_resp_i;
    logic        b_valid_i, b_ready_o;
    logic [31:0] r_data_i;
    logic        r_last_i, r_valid_i, r_ready_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    apb2axi_bridge dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i), .paddr_i(paddr_i),
        .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
        .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_prot_o(aw_prot_o),
        .aw_region_o(aw_region_o), .aw_qos_o(aw_qos_o), .aw_user_o(aw_user_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_user_i(b_user_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_prot_o(ar_prot_o),
        .ar_region_o(ar_region_o), .ar_qos_o(ar_qos_o), .ar_user_o(ar_user_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_user_i(r_user_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_idle();
        aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
        b_valid_i  = 1'b0; r_valid_i = 1'b0;
        b_resp_i   = 2'b00; r_resp_i = 2'b00; r_data_i = '0; r_last_i = 1'b0;
    endtask

    // One APB transfer against an AXI slave whose ready/response delays are given in cycles.
    // d_a: AW/AR ready delay after valid, d_w: W ready delay, d_r: B/R valid delay after the request.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d_a, input int d_w, input int d_r,
                        input logic [1:0] resp, input logic [31:0] rdat, input bit rst_mid);
        int          c, lat, exp_lat;
        int          aw_n, w_n, ar_n, b_n, r_n, cnt_a, cnt_w, cnt_r;
        bit          err_out, overlap, hit_rst;
        logic [31:0] got_addr, got_wdata;
        logic [40:0] got_ax;
        logic [10:0] got_w;
        lat = 0; aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
        cnt_a = 0; cnt_w = 0; cnt_r = 0;
        err_out = 0; overlap = 0; hit_rst = 0;
        got_addr = '0; got_wdata = '0; got_ax = '0; got_w = '0;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
        @(posedge clk); @(negedge clk);
        penable_i = 1'b1;
        c = 1;
        while (c < 150) begin
            if (rst_mid && b_ready_o) begin
                rst_ni = 1'b0;
                #1;
                hit_rst = 1;
                break;
            end
            if (pready_o) begin
                lat = c;
                break;
            end
            if (pslverr_o) err_out = 1;
            if (ar_valid_o && r_ready_o) overlap = 1;
            b_valid_i = (aw_n > 0) && (w_n > 0) && (b_n == 0) && (cnt_r >= d_r);
            b_resp_i  = resp;
            r_valid_i = (ar_n > 0) && (r_n == 0) && (cnt_r >= d_r);
            r_resp_i  = resp; r_data_i = rdat; r_last_i = 1'b1;
            if ((aw_n > 0 && w_n > 0) || ar_n > 0) cnt_r++;
            if (b_valid_i && b_ready_o) b_n++;
            if (r_valid_i && r_ready_o) r_n++;
            aw_ready_i = (aw_n > 0) || (aw_valid_o && cnt_a >= d_a);
            ar_ready_i = (ar_n > 0) || (ar_valid_o && cnt_a >= d_a);
            w_ready_i  = (w_n > 0)  || (w_valid_o && cnt_w >= d_w);
            if (aw_valid_o || ar_valid_o) cnt_a++;
            if (w_valid_o) cnt_w++;
            if (aw_valid_o && aw_ready_i) begin
                aw_n++;
                got_addr = aw_addr_o;
                got_ax = {aw_len_o, aw_size_o, aw_burst_o, aw_lock_o, aw_cache_o, aw_prot_o,
                          aw_region_o, aw_qos_o, aw_user_o, aw_id_o};
            end
            if (ar_valid_o && ar_ready_i) begin
                ar_n++;
                got_addr = ar_addr_o;
                got_ax = {ar_len_o, ar_size_o, ar_burst_o, ar_lock_o, ar_cache_o, ar_prot_o,
                          ar_region_o, ar_qos_o, ar_user_o, ar_id_o};
            end
            if (w_valid_o && w_ready_i) begin
                w_n++;
                got_wdata = w_data_o;
                got_w = {w_strb_o, w_last_o, w_user_o};
            end
            @(posedge clk); @(negedge clk);
            c++;
        end
        axi_idle();
        if (rst_mid) begin
            chk("rst_reached", 64'(hit_rst), 64'd1);
            chk("rst_ctrl_outs", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, pready_o, pslverr_o}, 0);
            chk("rst_prdata", prdata_o, 0);
            psel_i = 1'b0; penable_i = 1'b0;
            last_rd = '0;
        end else begin
            exp_lat = wr ? 4 + ((d_a > d_w) ? d_a : d_w) + d_r : 4 + d_a + d_r;
            chk(wr ? "wr_latency" : "rd_latency", 64'(lat), 64'(exp_lat));
            chk("pslverr_at_pready", 64'(pslverr_o), 64'(resp[1]));
            if (!wr) last_rd = rdat;
            chk("prdata_at_pready", prdata_o, last_rd);
            chk("pslverr_outside_done", 64'(err_out), 0);
            chk("ar_valid_with_r_ready", 64'(overlap), 0);
            chk("addr_beats", wr ? 64'(aw_n) : 64'(ar_n), 64'd1);
            chk("wrong_dir_beats", wr ? 64'(ar_n) : 64'(aw_n + w_n), 0);
            chk("axi_addr", got_addr, addr);
            chk("ax_const_fields", got_ax, {8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 6'd0});
            if (wr) begin
                chk("w_beats", 64'(w_n), 64'd1);
                chk("b_beats", 64'(b_n), 64'd1);
                chk("w_data", got_wdata, wdata);
                chk("w_strb_last_user", got_w, {4'hF, 1'b1, 6'd0});
            end else begin
                chk("r_beats", 64'(r_n), 64'd1);
            end
            @(posedge clk); @(negedge clk);
            chk("pready_one_cycle", {pready_o, pslverr_o}, 0);
            psel_i = 1'b0; penable_i = 1'b0;
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
        b_id_i = '0; b_user_i = '0; r_id_i = '0; r_user_i = '0;
        axi_idle();
        last_rd = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_outs", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, pready_o, pslverr_o}, 0);
        chk("reset_prdata", prdata_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        xfer(1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 32'h0, 0);
        @(negedge clk);
        xfer(0, 32'h0000_2004, 32'h0, 0, 0, 5, 2'b00, 32'hCAFE_F00D, 0);
        @(negedge clk);
        xfer(1, 32'h0000_3008, 32'h1234_5678, 0, 3, 0, 2'b00, 32'h0, 0);
        xfer(1, 32'h0000_300C, 32'h8765_4321, 2, 2, 1, 2'b01, 32'h0, 0);
        xfer(0, 32'h0000_4000, 32'h0, 1, 0, 0, 2'b10, 32'h5A5A_A5A5, 0);
        xfer(1, 32'h0000_4004, 32'h0BAD_F00D, 0, 0, 2, 2'b11, 32'h0, 0);
        xfer(0, 32'h0000_5000, 32'h0, 0, 0, 0, 2'b00, 32'h1111_2222, 0);
        xfer(0, 32'h0000_5004, 32'h0, 0, 0, 0, 2'b00, 32'h3333_4444, 0);

        xfer(1, 32'h0000_6000, 32'hFEED_FACE, 0, 0, 20, 2'b00, 32'h0, 1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        xfer(0, 32'h0000_6004, 32'h0, 0, 0, 0, 2'b00, 32'h7777_8888, 0);

        for (int i = 0; i < 24; i++) begin
            bit          wr;
            logic [31:0] a, d, rd;
            logic [1:0]  rs;
            int          gap;
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom & 32'hFFFF_FFFC;
            d   = $urandom;
            rd  = $urandom;
            rs  = 2'($urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            xfer(wr, a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rs, rd, 0);
            repeat (gap) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
